rr_arb_pld: RTL and testbench

Round-robin arbiter with an integrated payload path. It shares one downstream valid/ready channel between WIDTH upstream requesters. Each cycle it picks one requester with a rotating-priority onehot grant and steers that requester's payload through a onehot AND-OR mux into a single-entry output register. It sits in front of any shared consumer that can accept one beat per cycle and replaces ad-hoc fixed-priority selection.

---
 rtl/rr_arb_pld.sv | 115 +++++++++++
 tb/tb_rr_arb_pld.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rr_arb_pld.sv
// rr_arb_pld: round-robin arbiter with integrated payload path.
// Shares one downstream valid/ready channel between WIDTH requesters. Each
// cycle a rotating-priority onehot grant selects one requester, and its
// payload is steered through a onehot AND-OR mux into a single-entry output
// register.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   v_req_vld  per-requester valid
//   v_req_rdy  per-requester ready (onehot or zero)
//   v_req_pld  per-requester payload (unpacked array)
//   out_vld    downstream valid (registered)
//   out_rdy    downstream ready
//   out_pld    downstream payload (registered)
//   out_grant  onehot source of out_pld (registered), zero when out_vld=0
module rr_arb_pld #(
   parameter int WIDTH     = 4,
   parameter int PLD_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     v_req_vld,
   output logic [WIDTH-1:0]     v_req_rdy,
   input  logic [PLD_WIDTH-1:0] v_req_pld [WIDTH],
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [PLD_WIDTH-1:0] out_pld,
   output logic [WIDTH-1:0]     out_grant
);

   localparam int PTR_W = $clog2(WIDTH);

   logic                 out_vld_q,   out_vld_d;
   logic [PLD_WIDTH-1:0] out_pld_q,   out_pld_d;
   logic [WIDTH-1:0]     out_grant_q, out_grant_d;
   logic [PTR_W-1:0]     ptr_q,       ptr_d;

   logic                 load_en;
   logic                 any_grant;
   logic [WIDTH-1:0]     grant;
   logic [PTR_W-1:0]     grant_idx;
   logic [PLD_WIDTH-1:0] sel_pld;

   // Reset gates load_en so no requester sees ready while rst_n is low.
   assign load_en = (~out_vld_q | out_rdy) & rst_n;

   // Circular search starting at ptr; the first valid requester wins.
   always_comb begin
      int   idx;
      logic found;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < WIDTH; k++) begin
         idx = (int'(ptr_q) + k) % WIDTH;
         if (!found && v_req_vld[idx]) begin
            found          = 1'b1;
            grant[idx]     = 1'b1;
            grant_idx      = PTR_W'(idx);
         end
      end
   end

   assign any_grant = |grant;
   assign v_req_rdy = grant & {WIDTH{load_en}};

   // Onehot AND-OR payload mux, no index encode on the data path.
   always_comb begin
      sel_pld = '0;
      for (int i = 0; i < WIDTH; i++) begin
         sel_pld = sel_pld | (v_req_pld[i] & {PLD_WIDTH{grant[i]}});
      end
   end

   always_comb begin
      out_vld_d   = out_vld_q;
      out_pld_d   = out_pld_q;
      out_grant_d = out_grant_q;
      ptr_d       = ptr_q;
      if (load_en) begin
         out_vld_d   = any_grant;
         out_grant_d = grant;
         if (any_grant) begin
            out_pld_d = sel_pld;
            // Winner drops to lowest priority for the next round.
            if (grant_idx == PTR_W'(WIDTH - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = grant_idx + PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld_q   <= 1'b0;
         out_pld_q   <= '0;
         out_grant_q <= '0;
         ptr_q       <= '0;
      end else begin
         out_vld_q   <= out_vld_d;
         out_pld_q   <= out_pld_d;
         out_grant_q <= out_grant_d;
         ptr_q       <= ptr_d;
      end
   end

   assign out_vld   = out_vld_q;
   assign out_pld   = out_pld_q;
   assign out_grant = out_grant_q;

endmodule

// File: tb/tb_rr_arb_pld.sv
module tb_rr_arb_pld;

   logic        clk;
   logic        rst_n;
   logic [3:0]  v_req_vld;
   logic [3:0]  v_req_rdy;
   logic [31:0] v_req_pld [4];
   logic        out_vld;
   logic        out_rdy;
   logic [31:0] out_pld;
   logic [3:0]  out_grant;

   int total = 0;
   int bad   = 0;

   rr_arb_pld #(.WIDTH(4), .PLD_WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .v_req_vld (v_req_vld),
      .v_req_rdy (v_req_rdy),
      .v_req_pld (v_req_pld),
      .out_vld   (out_vld),
      .out_rdy   (out_rdy),
      .out_pld   (out_pld),
      .out_grant (out_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic vld, input logic [3:0] gnt,
                          input logic [31:0] pld);
      chk({tag, ".out_vld"},   32'(out_vld),   32'(vld));
      chk({tag, ".out_grant"}, 32'(out_grant), 32'(gnt));
      chk({tag, ".out_pld"},   out_pld,        pld);
   endtask

   logic [3:0]  exp_rot_g [5];
   logic [31:0] exp_rot_p [5];
   logic [3:0]  bp_vld [5];

   initial begin
      exp_rot_g[0] = 4'b0001; exp_rot_p[0] = 32'hA0;
      exp_rot_g[1] = 4'b0010; exp_rot_p[1] = 32'hA1;
      exp_rot_g[2] = 4'b0100; exp_rot_p[2] = 32'hA2;
      exp_rot_g[3] = 4'b1000; exp_rot_p[3] = 32'hA3;
      exp_rot_g[4] = 4'b0001; exp_rot_p[4] = 32'hA0;
      bp_vld[0] = 4'b0001; bp_vld[1] = 4'b0110; bp_vld[2] = 4'b1111;
      bp_vld[3] = 4'b0000; bp_vld[4] = 4'b1010;

      // Reset with every requester valid
      rst_n     = 1'b0;
      out_rdy   = 1'b1;
      v_req_vld = 4'b1111;
      for (int i = 0; i < 4; i++) v_req_pld[i] = 32'hA0 + 32'(i);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("reset.rdy", 32'(v_req_rdy), 32'h0);
         chk_out("reset", 1'b0, 4'b0000, 32'h0);
      end

      // Rotation: A0, A1, A2, A3, A0
      rst_n = 1'b1;
      #1;
      chk("release.rdy", 32'(v_req_rdy), 32'h1);
      for (int s = 0; s < 5; s++) begin
         tick();
         chk_out("rotate", 1'b1, exp_rot_g[s], exp_rot_p[s]);
      end
      // ptr = 1

      // Skip and wrap: grant 2 (ptr->3), then 1 via 3->0->1, then 2
      v_req_vld = 4'b0100;
      tick();
      chk_out("skip.g2", 1'b1, 4'b0100, 32'hA2);
      v_req_vld = 4'b0110;
      #1;
      chk("skip.rdy1", 32'(v_req_rdy), 32'b0010);
      tick();
      chk_out("skip.g1", 1'b1, 4'b0010, 32'hA1);
      tick();
      chk_out("skip.g2b", 1'b1, 4'b0100, 32'hA2);
      // ptr = 3

      // Backpressure: load 0x55 from requester 3, then stall 5 cycles
      v_req_pld[3] = 32'h55;
      v_req_vld    = 4'b1000;
      tick();
      chk_out("bp.load", 1'b1, 4'b1000, 32'h55);
      // ptr = 0
      out_rdy = 1'b0;
      for (int c = 0; c < 5; c++) begin
         v_req_vld = bp_vld[c];
         for (int i = 0; i < 3; i++) v_req_pld[i] = 32'h100 * 32'(c + 1) + 32'(i);
         #1;
         chk("bp.rdy", 32'(v_req_rdy), 32'h0);
         tick();
         chk_out("bp.hold", 1'b1, 4'b1000, 32'h55);
      end
      v_req_pld[0] = 32'hB0;
      v_req_vld    = 4'b1111;
      out_rdy      = 1'b1;
      #1;
      chk("bp.release_rdy", 32'(v_req_rdy), 32'b0001);
      tick();
      chk_out("bp.next", 1'b1, 4'b0001, 32'hB0);
      // ptr = 1

      // Idle gaps: single beat from requester 3
      v_req_pld[3] = 32'hC3;
      v_req_vld    = 4'b1000;
      tick();
      chk_out("idle.beat", 1'b1, 4'b1000, 32'hC3);
      v_req_vld = 4'b0000;
      tick();
      chk_out("idle.gap1", 1'b0, 4'b0000, 32'hC3);
      tick();
      chk_out("idle.gap2", 1'b0, 4'b0000, 32'hC3);
      v_req_vld = 4'b1111;
      #1;
      chk("idle.ptr0", 32'(v_req_rdy), 32'b0001);

      // Mid-stream reset while stalled
      out_rdy = 1'b0;
      tick();
      chk_out("mid.loaded", 1'b1, 4'b0001, 32'hB0);
      // ptr = 1
      rst_n = 1'b0;
      #1;
      chk("mid.rdy_stall", 32'(v_req_rdy), 32'h0);
      tick();
      chk_out("mid.reset", 1'b0, 4'b0000, 32'h0);
      out_rdy = 1'b1;
      #1;
      chk("mid.rdy_in_reset", 32'(v_req_rdy), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("mid.restart_rdy", 32'(v_req_rdy), 32'b0001);
      v_req_pld[0] = 32'hD0;
      tick();
      chk_out("mid.first", 1'b1, 4'b0001, 32'hD0);
      v_req_vld = 4'b0000;
      tick();
      chk_out("mid.drain", 1'b0, 4'b0000, 32'hD0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
